// File: rtl/frame_pkg.sv
// frame_pkg
// Shared types and helpers for the frame capture block.
//   PIXEL_W / WORD_W : pixel and memory word widths derived from global.vh
//   state_t          : capture FSM state encoding
//   clog2()          : ceil(log2(value)), never less than 1 so it can size ports
`include "global.vh"

package frame_pkg;

  localparam int PIXEL_W = `PIXEL_SIZE + 1;
  localparam int WORD_W  = `WORD_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/global.vh
// global.vh
// Project-wide pixel and memory word sizes shared by the frame capture path.
//   PIXEL_SIZE : pixel MSB index (pixel width is PIXEL_SIZE+1 bits)
//   WORD_SIZE  : frame-buffer word width in bits (must be >= PIXEL_SIZE+1)
`ifndef GLOBAL_VH
`define GLOBAL_VH

`define PIXEL_SIZE 7
`define WORD_SIZE  16

`endif

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with a registered head. The head word (dout) and its
// valid flag are registers loaded from the post-update pointers, so a word
// pushed into an empty FIFO is presented on the very next cycle.
//   clk, reset  : clock, asynchronous active-low reset
//   push, din   : write side (push ignored when full unless a pop also happens)
//   pop         : consume the head word (ignored when empty)
//   dout, valid : registered head word and its valid flag
//   full, empty : occupancy flags
module sync_fifo
  import frame_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4   // power of two, at least 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              do_push;
  logic              do_pop;
  logic              head_from_din;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push on a full FIFO is fine as long as the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // The incoming word becomes the head when nothing older remains after the pop;
  // the array copy is not written until this edge, so forward it directly.
  assign head_from_din = do_push && (count_nxt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      valid  <= (count_nxt != '0);
      if (head_from_din) begin
        dout <= din;
      end else if (count_nxt != '0) begin
        dout <= mem[rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/frame_capture.sv
// frame_capture
// Captures one WIDTH x HEIGHT frame of pixels from a valid/ready stream and
// writes it row-major into a frame buffer through a small FIFO, so memory
// back-pressure (mem_ready low) stalls the upstream instead of losing pixels.
//   clk, reset           : clock, asynchronous active-low reset
//   start                : arms capture of one frame (honoured only in IDLE)
//   en, data, ready      : upstream pixel stream; accept when en && ready
//   mem_we, mem_addr,
//   mem_wdata, mem_ready : frame-buffer write port; write completes on
//                          mem_we && mem_ready
//   x, y                 : position of the next pixel to accept
//   busy, done           : busy during CAPTURE/DRAIN, done pulses for one cycle
//
// state   | meaning
// IDLE    | waiting for start; nothing accepted, nothing written
// CAPTURE | accepting pixels while the FIFO drains to memory
// DRAIN   | whole frame accepted; finishing buffered writes
// DONE    | one-cycle done pulse, then back to IDLE
module frame_capture
  import frame_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int HEIGHT     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             en,
  input  logic [PIXEL_W-1:0]               data,
  output logic                             ready,
  output logic                             mem_we,
  output logic [clog2(WIDTH*HEIGHT)-1:0]   mem_addr,
  output logic [WORD_W-1:0]                mem_wdata,
  input  logic                             mem_ready,
  output logic [clog2(WIDTH)-1:0]          x,
  output logic [clog2(HEIGHT)-1:0]         y,
  output logic                             busy,
  output logic                             done
);

  localparam int TOTAL  = WIDTH * HEIGHT;
  localparam int ADDR_W = clog2(TOTAL);
  localparam int X_W    = clog2(WIDTH);
  localparam int Y_W    = clog2(HEIGHT);

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  accept_cnt;
  logic               accept;
  logic               last_accept;
  logic               write_done;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_valid;
  logic [PIXEL_W-1:0] fifo_dout;

  assign accept      = en && ready;
  assign last_accept = accept && (accept_cnt == ADDR_W'(TOTAL - 1));
  assign write_done  = mem_we && mem_ready;

  sync_fifo #(
    .DATA_W (PIXEL_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (data),
    .pop   (write_done),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The FIFO head register is the write port: it only moves on a completed
  // write, so address and data hold while mem_ready is low.
  assign mem_we    = fifo_valid;
  assign mem_wdata = WORD_W'(fifo_dout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CAPTURE;
      CAPTURE: if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !mem_we) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      CAPTURE: begin
        ready = !fifo_full;
        busy  = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x          <= '0;
      y          <= '0;
      accept_cnt <= '0;
      mem_addr   <= '0;
    end else if (state == IDLE && start) begin
      x          <= '0;
      y          <= '0;
      accept_cnt <= '0;
      mem_addr   <= '0;
    end else begin
      if (accept) begin
        accept_cnt <= accept_cnt + 1'b1;
        if (x == X_W'(WIDTH - 1)) begin
          x <= '0;
          y <= (y == Y_W'(HEIGHT - 1)) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      // Saturate on the last word so the address never wraps inside a frame.
      if (write_done && mem_addr != ADDR_W'(TOTAL - 1)) begin
        mem_addr <= mem_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
module tb_frame_capture;
  import frame_pkg::*;

  localparam int WIDTH      = 4;
  localparam int HEIGHT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TOTAL      = WIDTH * HEIGHT;
  localparam int ADDR_W     = clog2(TOTAL);
  localparam int X_W        = clog2(WIDTH);
  localparam int Y_W        = clog2(HEIGHT);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic               en = 1'b0;
  logic [PIXEL_W-1:0] data = '0;
  logic               mem_ready = 1'b0;
  logic               ready;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [WORD_W-1:0]  mem_wdata;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;

  // Observation log filled by step(); the tests compare it with the model.
  int cyc = 0;
  int n_acc, n_wr, max_occ, hold_viol, done_cnt, ready_low_en;
  int acc_x[$], acc_y[$], acc_cyc[$];
  int wr_addr[$], wr_data[$], wr_cyc[$];
  logic              prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [WORD_W-1:0] prev_data;

  // Reference frame: pixel k belongs at address k, position (k%WIDTH, k/WIDTH).
  logic [PIXEL_W-1:0] pix [TOTAL];

  frame_capture #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .en        (en),
    .data      (data),
    .ready     (ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic clear_log();
    n_acc = 0; n_wr = 0; max_occ = 0; hold_viol = 0; done_cnt = 0; ready_low_en = 0;
    acc_x.delete(); acc_y.delete(); acc_cyc.delete();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
  endtask

  task automatic random_pixels();
    for (int k = 0; k < TOTAL; k++) pix[k] = PIXEL_W'($urandom);
  endtask

  // Called at posedge+1: drive inputs for this cycle, observe, advance one cycle.
  task automatic step(input logic st, input logic e, input logic [PIXEL_W-1:0] d, input logic mr);
    start = st; en = e; data = d; mem_ready = mr;
    if (n_acc - n_wr > max_occ) max_occ = n_acc - n_wr;
    if (prev_stall && (!mem_we || mem_addr !== prev_addr || mem_wdata !== prev_data)) hold_viol++;
    if (e && !ready) ready_low_en++;
    if (e && ready) begin
      acc_x.push_back(int'(x)); acc_y.push_back(int'(y)); acc_cyc.push_back(cyc);
      n_acc++;
    end
    if (mem_we && mr) begin
      wr_addr.push_back(int'(mem_addr)); wr_data.push_back(int'(mem_wdata)); wr_cyc.push_back(cyc);
      n_wr++;
    end
    if (done) done_cnt++;
    prev_stall = mem_we && !mr;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
    @(posedge clk); #1;
    cyc++;
  endtask

  // en_mode 0: en always high, 1: every other cycle.
  // mr_mode 0: mem_ready high, 1: low for cycles 3..12, 2: random.
  // poke: pulse start mid-capture and in DONE, keep en high after the frame.
  task automatic run_frame(input int en_mode, input int mr_mode, input bit poke, input string name);
    bit timed_out;
    int i, after;
    logic e, mr, st;
    logic [PIXEL_W-1:0] d;
    step(1'b1, 1'b0, '0, 1'b1);
    i = 0; after = 0; timed_out = 0;
    while (after < 3) begin
      if (i >= 400) begin timed_out = 1; break; end
      e = (en_mode == 1) ? (i % 2 == 0) : 1'b1;
      if (n_acc >= TOTAL) e = poke;
      if (n_acc < TOTAL) d = pix[n_acc];
      else d = PIXEL_W'($urandom);
      case (mr_mode)
        1:       mr = !(i >= 3 && i < 13);
        2:       mr = 1'($urandom_range(0, 1));
        default: mr = 1'b1;
      endcase
      st = poke && (n_acc == 3 || done);
      if (done_cnt > 0) after++;
      step(st, e, d, mr);
      i++;
    end
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL %s timeout: done=%0d after 400 cycles, required a done pulse", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, mem_we, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: ready/we/busy/done=%b required 0000", {ready, mem_we, busy, done});
    end
    checks++;
    if (x !== '0 || y !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_pos: x=%0d y=%0d addr=%0d required 0 0 0", x, y, mem_addr);
    end
    reset = 1'b1;
    clear_log();
    repeat (3) step(1'b0, 1'b1, PIXEL_W'(8'hA5), 1'b1);
    checks++;
    if (n_acc !== 0 || mem_we !== 1'b0 || x !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: accepts=%0d we=%b x=%0d busy=%b required 0 0 0 0", n_acc, mem_we, x, busy);
    end
  endtask

  task automatic test_basic();
    clear_log();
    for (int k = 0; k < TOTAL; k++) pix[k] = PIXEL_W'(k + 1);
    run_frame(0, 0, 1'b0, "basic");
    checks++;
    if (n_wr !== TOTAL) begin
      errors++; $display("FAIL basic_count: writes=%0d required %0d", n_wr, TOTAL);
    end
    for (int k = 0; k < TOTAL && k < n_wr; k++) begin
      checks++;
      if (wr_addr[k] !== k || wr_data[k] !== k + 1) begin
        errors++;
        $display("FAIL basic_write %0d: addr=%0d data=%0h required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, k + 1);
      end
    end
    for (int k = 0; k < TOTAL && k < n_wr && k < n_acc; k++) begin
      checks++;
      if (wr_cyc[k] !== acc_cyc[k] + 1) begin
        errors++;
        $display("FAIL basic_latency %0d: write cycle=%0d required %0d", k, wr_cyc[k], acc_cyc[k] + 1);
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done: pulses=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_stall();
    clear_log();
    random_pixels();
    run_frame(0, 1, 1'b0, "stall");
    checks++;
    if (max_occ !== FIFO_DEPTH || ready_low_en == 0) begin
      errors++;
      $display("FAIL stall_backpressure: max buffered=%0d ready-low cycles=%0d required %0d and >0", max_occ, ready_low_en, FIFO_DEPTH);
    end
    checks++;
    if (hold_viol !== 0) begin
      errors++; $display("FAIL stall_hold: unstable stalled cycles=%0d required 0", hold_viol);
    end
    checks++;
    if (n_wr !== TOTAL) begin
      errors++; $display("FAIL stall_count: writes=%0d required %0d", n_wr, TOTAL);
    end
    for (int k = 0; k < TOTAL && k < n_wr; k++) begin
      checks++;
      if (wr_addr[k] !== k || wr_data[k] !== int'(pix[k])) begin
        errors++;
        $display("FAIL stall_write %0d: addr=%0d data=%0h required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, pix[k]);
      end
    end
  endtask

  task automatic test_toggle();
    clear_log();
    random_pixels();
    run_frame(1, 2, 1'b0, "toggle");
    checks++;
    if (n_acc !== TOTAL || n_wr !== TOTAL) begin
      errors++; $display("FAIL toggle_count: accepts=%0d writes=%0d required %0d", n_acc, n_wr, TOTAL);
    end
    for (int k = 0; k < TOTAL && k < n_acc; k++) begin
      checks++;
      if (acc_x[k] !== k % WIDTH || acc_y[k] !== k / WIDTH) begin
        errors++;
        $display("FAIL toggle_xy %0d: (%0d,%0d) required (%0d,%0d)", k, acc_x[k], acc_y[k], k % WIDTH, k / WIDTH);
      end
    end
    for (int k = 0; k < TOTAL && k < n_wr; k++) begin
      checks++;
      if (wr_addr[k] !== k || wr_data[k] !== int'(pix[k])) begin
        errors++;
        $display("FAIL toggle_write %0d: addr=%0d data=%0h required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, pix[k]);
      end
    end
    checks++;
    if (hold_viol !== 0 || done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_end: hold violations=%0d pulses=%0d busy=%b required 0 1 0", hold_viol, done_cnt, busy);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    clear_log();
    random_pixels();
    step(1'b1, 1'b0, '0, 1'b1);
    guard = 0;
    while (n_acc < 5 && guard < 50) begin
      step(1'b0, 1'b1, pix[n_acc], 1'b1);
      guard++;
    end
    checks++;
    if (busy !== 1'b1 || mem_we !== 1'b1 || x !== X_W'(1) || y !== Y_W'(1)) begin
      errors++;
      $display("FAIL midreset_pre: busy=%b we=%b x=%0d y=%0d required 1 1 1 1", busy, mem_we, x, y);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({ready, mem_we, busy, done} !== 4'b0000 || x !== '0 || y !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL midreset_async: ready/we/busy/done=%b x=%0d y=%0d addr=%0d required 0000 0 0 0",
               {ready, mem_we, busy, done}, x, y, mem_addr);
    end
    en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_log();
    random_pixels();
    run_frame(0, 2, 1'b0, "midreset");
    checks++;
    if (n_wr !== TOTAL) begin
      errors++; $display("FAIL midreset_count: writes=%0d required %0d", n_wr, TOTAL);
    end
    for (int k = 0; k < TOTAL && k < n_wr; k++) begin
      checks++;
      if (wr_addr[k] !== k || wr_data[k] !== int'(pix[k])) begin
        errors++;
        $display("FAIL midreset_write %0d: addr=%0d data=%0h required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, pix[k]);
      end
    end
  endtask

  task automatic test_ignore();
    clear_log();
    random_pixels();
    run_frame(0, 2, 1'b1, "ignore");
    checks++;
    if (n_acc !== TOTAL || n_wr !== TOTAL) begin
      errors++; $display("FAIL ignore_count: accepts=%0d writes=%0d required %0d", n_acc, n_wr, TOTAL);
    end
    for (int k = 0; k < TOTAL && k < n_wr; k++) begin
      checks++;
      if (wr_addr[k] !== k || wr_data[k] !== int'(pix[k])) begin
        errors++;
        $display("FAIL ignore_write %0d: addr=%0d data=%0h required addr=%0d data=%0h", k, wr_addr[k], wr_data[k], k, pix[k]);
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_done: pulses=%0d busy=%b required 1 0", done_cnt, busy);
    end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_ignore();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 16, pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 16, rows per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, buffered pixels, power of two, at least 2.
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-low, port named reset.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, arms capture of one frame.
REQ-008 SHALL have port en, input, 1 bit, upstream pixel valid.
REQ-009 SHALL have port data, input, `PIXEL_SIZE+1 bits, upstream pixel.
REQ-010 SHALL have port ready, output, 1 bit, pixel accepted when en and ready are both high.
REQ-011 SHALL have port mem_we, output, 1 bit, frame-buffer write strobe.
REQ-012 SHALL have port mem_addr, output, clog2(WIDTH*HEIGHT) bits, word address.
REQ-013 SHALL have port mem_wdata, output, `WORD_SIZE bits, pixel zero-extended.
REQ-014 SHALL have port mem_ready, input, 1 bit; a write completes in a cycle with mem_we and mem_ready both high.
REQ-015 SHALL have ports x and y, outputs, clog2(WIDTH) and clog2(HEIGHT) bits, position of the next pixel to accept.
REQ-016 SHALL have ports busy and done, outputs, 1 bit each; done is a one-cycle pulse.

Function
REQ-017 SHALL implement FSM states IDLE, CAPTURE, DRAIN and DONE.
REQ-018 IDLE: ready=0 and mem_we=0; start moves to CAPTURE and clears x, y, mem_addr and the accept count.
REQ-019 CAPTURE: ready = FIFO not full; each accept pushes data and advances x; x wraps at WIDTH-1 to 0 and then increments y.
REQ-020 On the WIDTH*HEIGHT-th accept, SHALL move to DRAIN in the next cycle; ready is 0 from that cycle on.
REQ-021 DRAIN: moves to DONE when the FIFO is empty and no write is pending.
REQ-022 DONE: done=1 for exactly one cycle, then returns to IDLE.
REQ-023 busy SHALL be 1 in CAPTURE and DRAIN, and 0 otherwise.
REQ-024 mem_we SHALL be driven by a register and asserted whenever the FIFO head is valid; mem_wdata and mem_addr SHALL hold stable while mem_we=1 and mem_ready=0.
REQ-025 Minimum latency from accept (cycle N) to mem_we=1 with that pixel SHALL be cycle N+1.
REQ-026 mem_addr SHALL increment by 1 per completed write, starting at 0 and ending at WIDTH*HEIGHT-1; it never wraps within a frame.
REQ-027 A simultaneous push and pop on a full FIFO SHALL be allowed; ready stays combinational on the full flag only.
REQ-028 en while ready=0 SHALL be ignored, with no state change.
REQ-029 start while busy or in DONE SHALL be ignored.
REQ-030 Pixel order in memory SHALL equal accept order (row-major), with no loss or duplication under any mem_ready pattern.

Reset
REQ-031 Asserting reset (0) at any time SHALL asynchronously force IDLE, FIFO empty, x=y=0, mem_addr=0, mem_we=0, ready=0, busy=0 and done=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; the next start begins at address 0.

Structure
REQ-033 SHALL take `PIXEL_SIZE and `WORD_SIZE from global.vh; the FSM state enum and the CLOG2 helper SHALL live in a shared package frame_pkg.
REQ-034 The buffer SHALL be a separate sub-module sync_fifo, parameterised by width and depth, with full and empty flags.

Verification
REQ-035 WIDTH=4, HEIGHT=2, mem_ready=1, start then en=1 with data 1..8 -> mem writes addr 0..7 with data 1..8, done pulses once, busy ends low.
REQ-036 mem_ready=0 for 10 cycles mid-frame, FIFO_DEPTH=4 -> ready drops after 4 buffered pixels and mem_addr/mem_wdata hold steady; all 8 pixels are still written in order.
REQ-037 en toggling every other cycle, mem_ready random -> x/y run (0,0),(1,0)..(3,1); the memory image equals the input sequence.
REQ-038 Reset pulled low after pixel 5 -> outputs take reset values immediately; a new start and 8 pixels -> writes begin at addr 0.
REQ-039 start pulsed during CAPTURE, and en held high after the 8th pixel -> start has no effect; extra pixels are not accepted (ready=0); exactly 8 writes occur.
